// File: rtl/gpio_out_pkg.sv
// ---------------------------------------------------------------------------
// gpio_out_pkg
//   Shared definitions for the GPIO output drivers: mode codes of the IO
//   register "mode" field and the state encoding of gpio_out_driver.
// ---------------------------------------------------------------------------
package gpio_out_pkg;

    // Mode field codes; 2'b11 is reserved and behaves as MODE_LEVEL.
    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    // Driver state enumeration (kept as plain constants for legacy tools).
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_PULSE_ON  = 3'd1;
    localparam state_t ST_GUARD     = 3'd2;
    localparam state_t ST_BLINK_ON  = 3'd3;
    localparam state_t ST_BLINK_OFF = 3'd4;

endpackage

// File: rtl/hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
//   Saturating up-counter measuring how long a pin has been stable.
//   Reset leaves it saturated so the very first change is never delayed.
// Ports
//   clk   in  1  system clock
//   rst   in  1  asynchronous, active-high reset
//   clear in  1  the pin changes at this edge; restart the count
//   sat   out 1  the pin will have been stable for HOLD cycles including the
//                current one, so a change decided now is allowed
// ---------------------------------------------------------------------------
module hold_timer #(
    parameter int CNT_W = 16,
    parameter int HOLD  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sat
);

    localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

    logic [CNT_W-1:0] cnt_r;

    // Stability counter: cleared on a pin transition, saturates at HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= HOLD_V;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r != HOLD_V) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The count is 0 during the first cycle of a new value, so HOLD-1 already
    // means HOLD stable cycles once the current cycle is included.
    assign sat = (cnt_r >= HOLD_M1);

endmodule

// File: rtl/gpio_out_driver.sv
// ---------------------------------------------------------------------------
// gpio_out_driver
//   Drives one pad (LED, relay, buzzer) from IO-register commands with
//   glitch-free transitions and a minimum hold time. Modes: steady level,
//   one-shot pulse, blink.
// Ports
//   clk   in  1      system clock
//   rst   in  1      asynchronous, active-high reset
//   mode  in  2      00 LEVEL, 01 PULSE, 10 BLINK, 11 reserved (LEVEL)
//   level in  1      requested level (LEVEL) / blink enable (BLINK)
//   trig  in  1      pulse start strobe (PULSE)
//   len   in  CNT_W  pulse length / blink half-period, 0 treated as 1
//   out   out 1      registered pin drive
//   busy  out 1      high whenever the driver is not IDLE
//   done  out 1      one-cycle strobe when a pulse/blink guard completes
// ---------------------------------------------------------------------------
module gpio_out_driver
    import gpio_out_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int HOLD  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             level,
    input  logic             trig,
    input  logic [CNT_W-1:0] len,
    output logic             out,
    output logic             busy,
    output logic             done
);

    // Phase counter reload: a phase lasts max(len,1) cycles, counted down to 0.
    function automatic logic [CNT_W-1:0] len_reload(input logic [CNT_W-1:0] l);
        if (l == '0) begin
            return '0;
        end else begin
            return l - CNT_W'(1);
        end
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] reload_r, reload_s;
    logic             out_r, out_s;
    logic             busy_r;
    logic             done_r, done_s;
    logic             hold_sat_s;
    logic             hold_clear_s;

    // Any change of the pin restarts the stability measurement.
    assign hold_clear_s = (out_s != out_r);

    hold_timer #(
        .CNT_W (CNT_W),
        .HOLD  (HOLD)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (hold_clear_s),
        .sat   (hold_sat_s)
    );

    // Next-state logic; mode and len only matter in IDLE, so edits while busy
    // take effect once the driver returns there.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        reload_s = reload_r;
        out_s    = out_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                case (mode)
                    MODE_PULSE: begin
                        if (trig) begin
                            state_s = ST_PULSE_ON;
                            out_s   = 1'b1;
                            cnt_s   = len_reload(len);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                    MODE_BLINK: begin
                        if (level) begin
                            state_s  = ST_BLINK_ON;
                            out_s    = 1'b1;
                            cnt_s    = len_reload(len);
                            reload_s = len_reload(len);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                    default: begin
                        // Latest level wins; a request that reverts before the
                        // hold expires never reaches the pin.
                        if ((level != out_r) && hold_sat_s) begin
                            out_s = level;
                        end else begin
                            out_s = out_r;
                        end
                    end
                endcase
            end
            ST_PULSE_ON: begin
                if (cnt_r == '0) begin
                    state_s = ST_GUARD;
                    out_s   = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (hold_sat_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_GUARD;
                end
            end
            ST_BLINK_ON: begin
                if (cnt_r == '0) begin
                    state_s = ST_BLINK_OFF;
                    out_s   = 1'b0;
                    cnt_s   = reload_r;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_BLINK_OFF: begin
                // level is only looked at here, so a blink is never truncated.
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else if (level) begin
                    state_s = ST_BLINK_ON;
                    out_s   = 1'b1;
                    cnt_s   = reload_r;
                end else begin
                    state_s = ST_GUARD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                out_s   = 1'b0;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            reload_r <= '0;
            out_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            reload_r <= reload_s;
            out_r    <= out_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= done_s;
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
